alu_serial: RTL and testbench
=============================

Name: alu_serial

Overview:
- Parametrised, digit-serial successor to the single-bit ALU slice. Processes DIGIT bits of a WIDTH-bit operation per clock.
- Uses the same 3-bit aluCont operation encoding as the slice.
- Produces full-width result plus negative (set-less-than), overflow, carry_out and zero flags.
- Sits beside the datapath as an area-reduced multi-cycle ALU, driven by a start/done handshake from the control FSM.

Parameters:
- WIDTH, 32, operand/result width in bits.
- DIGIT, 4, bits processed per cycle. WIDTH % DIGIT must be 0; N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- aluCont  input  3  [2] invert b (and carry-in 1 for arithmetic); [1:0] 00 AND, 01 OR, 10 XOR, 11 ADD.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result and flags are valid.
- result  output  WIDTH  operation result, held until the next accepted start.
- negative  output  1  arithmetic: overflow XOR result[WIDTH-1]; logic ops: 0.
- overflow  output  1  arithmetic: carry into MSB XOR carry out of MSB; logic ops: 0.
- carry_out  output  1  arithmetic: carry out of MSB (SUB: 1 = no borrow); logic ops: 0.
- zero  output  1  result == 0, for all ops.

Behaviour:
- Reset: state IDLE; busy=0, done=0, result=0, all flags 0, digit counter 0, carry register 0. Reset overrides everything, including mid-RUN, and discards the operation in flight.
- States:
  - IDLE -> RUN on start.
  - RUN -> RUN while counter < N-1.
  - RUN -> DONE after digit N-1 is processed.
  - DONE -> RUN if start; otherwise DONE -> IDLE.
- Start acceptance (IDLE or DONE):
  - latch a, b, aluCont;
  - effective b = b XOR {WIDTH{aluCont[2]}};
  - carry register = aluCont[2] & aluCont[1] & aluCont[0];
  - counter = 0; result/flags keep their old values until overwritten.
- RUN, each cycle, digit d = counter:
  - compute bits [d*DIGIT +: DIGIT] of the selected op on latched a and effective b;
  - for ADD, ripple the carry through the DIGIT bits starting from the carry register, then store the digit's carry-out back in the carry register;
  - write the digit into result; counter increments.
- Last digit: overflow, carry_out, negative and zero are computed from the MSB carries and the final result, and become visible with done.
- Latency: start accepted at edge k -> done=1 in the cycle after edge k+N; busy=1 for exactly N cycles.
- start in RUN is ignored; there is no queueing.
- start in DONE gives back-to-back operation: busy rises the next cycle and done drops.
- result and flags stay stable from done until the edge after the next accepted start's first digit.
- N=1 (DIGIT=WIDTH) is legal: single RUN cycle.

Test Plan (WIDTH=32, DIGIT=4, N=8):
- ADD (011), a=0x7FFFFFFF, b=1 -> result 0x80000000, overflow=1, negative=0, carry_out=0, zero=0; done exactly 8 cycles after the start edge, busy high for 8 cycles.
- SUB (111), a=5, b=7 -> result 0xFFFFFFFE, negative=1, carry_out=0, overflow=0. Then a=7, b=7 -> result 0, zero=1, carry_out=1.
- AND (000), a=0xF0F0F0F0, b=0xFF00FF00 -> result 0xF000F000, overflow=0, carry_out=0, negative=0. Also XOR with invert (110), a=0, b=0 -> result 0xFFFFFFFF.
- SUB (111), a=0x80000000, b=1 -> result 0x7FFFFFFF, overflow=1, negative=1 (signed min < 1).
- start pulsed again at RUN cycle 3 -> ignored; first result unchanged, single done. Back-to-back start in the DONE cycle -> second done 8 cycles later.
- reset asserted at RUN cycle 5 -> next cycle IDLE, busy=0, done=0, result=0; no done pulse follows.

Source files
------------

// File: rtl/alu_serial.sv
// Digit-serial ALU: a WIDTH-bit AND/OR/XOR/ADD(SUB) done DIGIT bits per clock over N cycles,
// with start/done handshake and set-less-than, overflow, carry and zero flags.
module alu_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       aluCont,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             overflow,
   output logic             carry_out,
   output logic             zero
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

   // b is stored already inverted so the digit datapath never looks at aluCont[2]
   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [1:0]       op;
   } opReq;

   stateT         state;
   opReq          req;
   logic [CW-1:0] cnt;
   logic          carry;

   logic [DIGIT-1:0] aDig, bDig, resDig;
   logic [DIGIT:0]   chain;
   logic [WIDTH-1:0] resNext;
   logic             isArith, lastDig, ovNext, coNext, negNext, zeroNext;

   assign isArith = &req.op;
   assign lastDig = (cnt == LAST);
   assign aDig    = req.a[int'(cnt)*DIGIT +: DIGIT];
   assign bDig    = req.b[int'(cnt)*DIGIT +: DIGIT];
   assign chain[0] = carry;

   for (genvar i = 0; i < DIGIT; i++) begin : gBit
      assign chain[i+1] = (aDig[i] & bDig[i]) | (chain[i] & (aDig[i] ^ bDig[i]));
      assign resDig[i]  = (req.op == 2'b00) ? (aDig[i] & bDig[i]) :
                          (req.op == 2'b01) ? (aDig[i] | bDig[i]) :
                          (aDig[i] ^ bDig[i] ^ (req.op[0] & chain[i]));
   end

   always_comb begin
      resNext = result;
      resNext[int'(cnt)*DIGIT +: DIGIT] = resDig;
   end

   // Flags only matter on the last digit, where chain sees the MSB carries
   assign ovNext   = isArith & (chain[DIGIT] ^ chain[DIGIT-1]);
   assign coNext   = isArith & chain[DIGIT];
   assign negNext  = isArith & (ovNext ^ resNext[WIDTH-1]);
   assign zeroNext = (resNext == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         req       <= '0;
         cnt       <= '0;
         carry     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         negative  <= 1'b0;
         overflow  <= 1'b0;
         carry_out <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  req.a  <= a;
                  req.b  <= b ^ {WIDTH{aluCont[2]}};
                  req.op <= aluCont[1:0];
                  carry  <= &aluCont;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               result <= resNext;
               if (isArith) carry <= chain[DIGIT];
               cnt <= cnt + CW'(1);
               if (lastDig) begin
                  negative  <= negNext;
                  overflow  <= ovNext;
                  carry_out <= coNext;
                  zero      <= zeroNext;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial (WIDTH=32, DIGIT=4): results, flags, latency, handshake, reset.
module tb_alu_serial;

   logic        clk, reset, start;
   logic [2:0]  aluCont;
   logic [31:0] a, b, result;
   logic        busy, done, negative, overflow, carry_out, zero;

   int total = 0;
   int bad   = 0;

   alu_serial #(.WIDTH(32), .DIGIT(4)) dut (
      .clk(clk), .reset(reset), .start(start), .aluCont(aluCont), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .negative(negative),
      .overflow(overflow), .carry_out(carry_out), .zero(zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Wait for done; lat = edges from acceptance to done, bc = cycles busy was seen high
   task automatic waitDone(output int lat, output int bc);
      lat = -1;
      bc  = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (busy) bc++;
         if (done) begin
            lat = i - 1;
            break;
         end
      end
   endtask

   task automatic issue(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
      aluCont = c; a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic doOp(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bc);
      @(negedge clk);
      issue(c, x, y);
      waitDone(lat, bc);
   endtask

   int lat, bc, doneCnt, firstDone;

   initial begin
      reset = 1'b1; start = 1'b0; aluCont = 3'b000; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst result", result, 0);
      chk("rst flags", {negative, overflow, carry_out, zero}, 4'b0000);
      reset = 1'b0;

      // flags packed as {negative, overflow, carry_out, zero}
      doOp(3'b011, 32'h7FFF_FFFF, 32'h1, lat, bc);
      chk("add lat", lat, 8);
      chk("add busy", bc, 8);
      chk("add res", result, 32'h8000_0000);
      chk("add flags", {negative, overflow, carry_out, zero}, 4'b0100);

      doOp(3'b111, 32'd5, 32'd7, lat, bc);
      chk("sub57 res", result, 32'hFFFF_FFFE);
      chk("sub57 flags", {negative, overflow, carry_out, zero}, 4'b1000);

      doOp(3'b111, 32'd7, 32'd7, lat, bc);
      chk("sub77 res", result, 32'h0);
      chk("sub77 flags", {negative, overflow, carry_out, zero}, 4'b0011);

      doOp(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, bc);
      chk("and res", result, 32'hF000_F000);
      chk("and flags", {negative, overflow, carry_out, zero}, 4'b0000);

      doOp(3'b110, 32'h0, 32'h0, lat, bc);
      chk("xorinv res", result, 32'hFFFF_FFFF);
      chk("xorinv flags", {negative, overflow, carry_out, zero}, 4'b0000);

      doOp(3'b111, 32'h8000_0000, 32'h1, lat, bc);
      chk("submin res", result, 32'h7FFF_FFFF);
      chk("submin flags", {negative, overflow, carry_out, zero}, 4'b1110);

      // start during RUN must be ignored
      @(negedge clk);
      issue(3'b011, 32'd1, 32'd2);
      doneCnt = 0; firstDone = -1;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (done) begin
            doneCnt++;
            if (firstDone < 0) firstDone = i - 1;
         end
         if (i == 3) begin
            aluCont = 3'b001; a = 32'h100; b = 32'h100; start = 1'b1;
         end
         if (i == 4) start = 1'b0;
      end
      chk("ign lat", firstDone, 8);
      chk("ign dones", doneCnt, 1);
      chk("ign res", result, 32'd3);

      // back-to-back start in the DONE cycle
      doOp(3'b011, 32'd10, 32'd20, lat, bc);
      chk("b2b res1", result, 32'd30);
      issue(3'b001, 32'h100, 32'h200);
      waitDone(lat, bc);
      chk("b2b lat", lat, 8);
      chk("b2b busy", bc, 8);
      chk("b2b res2", result, 32'h300);

      // reset mid-RUN discards the operation
      @(negedge clk);
      issue(3'b011, 32'h1234, 32'h1111);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("mrst busy", busy, 0);
      chk("mrst done", done, 0);
      chk("mrst res", result, 0);
      doneCnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) doneCnt++;
      end
      chk("mrst quiet", doneCnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
